// File: rtl/sd_wb_master_arbiter_if.sv
// WISHBONE master-side signal bundle. The same type carries a filler's request
// (filler = master, arbiter = slave) and the shared m_wb_* pins (arbiter = master).
interface sd_wb_master_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    logic          ack;
    logic          err;
    logic          yield;

    modport master (output cyc, stb, we, adr, dat, sel, input  ack, err, yield);
    modport slave  (input  cyc, stb, we, adr, dat, sel, output ack, err, yield);
endinterface

// File: rtl/sd_wb_master_arbiter.sv
// Round-robin owner of the single WISHBONE master port, shared by the TX (read) and RX (write) FIFO fillers.
// Define SD_ARB_TIMEOUT_EN to add the stalled-slave abort (TIMEOUT cycles of stb without ack).
module sd_wb_master_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    sd_wb_master_arbiter_if.slave         tx_if,
    sd_wb_master_arbiter_if.slave         rx_if,
    sd_wb_master_arbiter_if.master        m_wb_if,
    output logic [1:0]                    gnt_o
);

    if (MAX_BEATS < 1 || TIMEOUT < 1) begin : g_param_check
        $error("sd_wb_master_arbiter: MAX_BEATS and TIMEOUT must be >= 1");
    end

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, GNT_TX, GNT_RX, GAP} state_e;
    typedef enum logic       {SIDE_TX, SIDE_RX}          side_e;

    state_e        state_q, state_d;
    side_e         last_q, last_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic          granted;
    logic          own_cyc;
    logic          own_stb;
    logic          own_we;
    logic [AW-1:0] own_adr;
    logic          ack_beat;
    logic          timeout_hit;
    logic          tx_blk;
    logic          rx_blk;
    logic          tx_req;
    logic          rx_req;

    // Holder's request, selected by the registered grant.
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        case (state_q)
            GNT_TX: begin
                own_cyc = tx_if.cyc;
                own_stb = tx_if.stb;
                own_we  = tx_if.we;
                own_adr = tx_if.adr;
            end
            GNT_RX: begin
                own_cyc = rx_if.cyc;
                own_stb = rx_if.stb;
                own_we  = rx_if.we;
                own_adr = rx_if.adr;
            end
            default: ;
        endcase
    end

    assign granted  = (state_q == GNT_TX) || (state_q == GNT_RX);
    assign ack_beat = granted && own_stb && m_wb_if.ack;
    assign tx_req   = tx_if.cyc && !tx_blk;
    assign rx_req   = rx_if.cyc && !rx_blk;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          blk_tx_q, blk_tx_d;
    logic          blk_rx_q, blk_rx_d;

    // Fires during the TIMEOUT-th consecutive stalled strobe cycle.
    assign timeout_hit = granted && own_cyc && own_stb && !m_wb_if.ack && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        wait_cnt_d = '0;
        blk_tx_d   = blk_tx_q;
        blk_rx_d   = blk_rx_q;
        if (granted && own_stb && !m_wb_if.ack && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (timeout_hit) begin
            if (state_q == GNT_TX) blk_tx_d = 1'b1;
            else                   blk_rx_d = 1'b1;
        end
        // An aborted holder must be seen idle once before it can own the bus again.
        if (state_q == IDLE && !tx_if.cyc) blk_tx_d = 1'b0;
        if (state_q == IDLE && !rx_if.cyc) blk_rx_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wait_cnt_q <= '0;
            blk_tx_q   <= 1'b0;
            blk_rx_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            blk_tx_q   <= blk_tx_d;
            blk_rx_q   <= blk_rx_d;
        end
    end

    assign tx_blk    = blk_tx_q;
    assign rx_blk    = blk_rx_q;
    assign tx_if.err = timeout_hit && (state_q == GNT_TX);
    assign rx_if.err = timeout_hit && (state_q == GNT_RX);
`else
    assign timeout_hit = 1'b0;
    assign tx_blk      = 1'b0;
    assign rx_blk      = 1'b0;
    assign tx_if.err   = 1'b0;
    assign rx_if.err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                // On a tie the side that did not own the bus last wins.
                if (tx_req && (!rx_req || last_q == SIDE_RX)) begin
                    state_d = GNT_TX;
                    last_d  = SIDE_TX;
                end else if (rx_req) begin
                    state_d = GNT_RX;
                    last_d  = SIDE_RX;
                end
            end
            GNT_TX, GNT_RX: begin
                if (ack_beat && beat_cnt_q != BEAT_MAX) beat_cnt_d = beat_cnt_q + 1'b1;
                if (!own_cyc || timeout_hit) state_d = GAP;
            end
            GAP: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_q     <= SIDE_RX;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Bus outputs are decoded from the registered state, so reset drops cyc/stb immediately.
    always_comb begin
        m_wb_if.cyc  = granted && !timeout_hit;
        m_wb_if.stb  = own_stb && !timeout_hit;
        m_wb_if.we   = own_we;
        m_wb_if.adr  = own_adr;
        m_wb_if.dat  = granted ? rx_if.dat : '0;
        m_wb_if.sel  = 4'hF;
        tx_if.ack    = (state_q == GNT_TX) && ack_beat;
        rx_if.ack    = (state_q == GNT_RX) && ack_beat;
        tx_if.yield  = (state_q == GNT_TX) && rx_if.cyc && (beat_cnt_q == BEAT_MAX);
        rx_if.yield  = (state_q == GNT_RX) && tx_if.cyc && (beat_cnt_q == BEAT_MAX);
    end

    always_comb begin
        case (state_q)
            GNT_TX:  gnt_o = 2'b01;
            GNT_RX:  gnt_o = 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_sd_wb_master_arbiter.sv
// Directed bench for sd_wb_master_arbiter; the timeout scenario follows SD_ARB_TIMEOUT_EN.
module tb_sd_wb_master_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BEATS = 16;
    localparam int TIMEOUT   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    int         n_assert = 0;
    int         n_fail   = 0;

    sd_wb_master_arbiter_if #(.AW(AW), .DW(DW)) tx_if ();
    sd_wb_master_arbiter_if #(.AW(AW), .DW(DW)) rx_if ();
    sd_wb_master_arbiter_if #(.AW(AW), .DW(DW)) m_if ();

    sd_wb_master_arbiter #(
        .AW(AW), .DW(DW), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .tx_if    (tx_if),
        .rx_if    (rx_if),
        .m_wb_if  (m_if),
        .gnt_o    (gnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        tx_if.cyc = 1'b0; tx_if.stb = 1'b0; tx_if.we = 1'b0; tx_if.adr = '0; tx_if.dat = '0; tx_if.sel = 4'hF;
        rx_if.cyc = 1'b0; rx_if.stb = 1'b0; rx_if.we = 1'b0; rx_if.adr = '0; rx_if.dat = '0; rx_if.sel = 4'hF;
        m_if.ack = 1'b0; m_if.err = 1'b0; m_if.yield = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        n_assert++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        n_assert++;
        if ({m_if.cyc, m_if.stb, m_if.we} !== 3'b000 || m_if.adr !== '0 || m_if.dat !== '0) begin
            n_fail++; $display("FAIL reset_bus: cyc/stb/we %b%b%b adr %h dat %h want all 0", m_if.cyc, m_if.stb, m_if.we, m_if.adr, m_if.dat);
        end
        n_assert++;
        if (m_if.sel !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %h want f", m_if.sel); end
        n_assert++;
        if ({tx_if.ack, tx_if.err, tx_if.yield, rx_if.ack, rx_if.err, rx_if.yield} !== 6'b0) begin
            n_fail++; $display("FAIL reset_side_outs: got %b want 000000", {tx_if.ack, tx_if.err, tx_if.yield, rx_if.ack, rx_if.err, rx_if.yield});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_tx_only();
        int tx_acks = 0;
        int rx_acks = 0;
        tx_if.cyc = 1'b1; tx_if.stb = 1'b1; tx_if.adr = 32'h0000_1000;
        #1;
        n_assert++;
        if (m_if.cyc !== 1'b0) begin n_fail++; $display("FAIL tx_only_latency: cyc_o %b before grant edge, want 0", m_if.cyc); end
        tick();
        n_assert++;
        if (gnt !== 2'b01 || m_if.cyc !== 1'b1 || m_if.stb !== 1'b1) begin
            n_fail++; $display("FAIL tx_only_grant: gnt %b cyc %b stb %b want 01 1 1", gnt, m_if.cyc, m_if.stb);
        end
        n_assert++;
        if (m_if.adr !== 32'h0000_1000 || m_if.we !== 1'b0) begin
            n_fail++; $display("FAIL tx_only_adr: adr %h we %b want 00001000 0", m_if.adr, m_if.we);
        end
        for (int i = 0; i < 4; i++) begin
            m_if.ack = 1'b1;
            #1;
            if (tx_if.ack === 1'b1) tx_acks++;
            if (rx_if.ack !== 1'b0) rx_acks++;
            tick();
        end
        m_if.ack = 1'b0;
        n_assert++;
        if (tx_acks != 4 || rx_acks != 0) begin n_fail++; $display("FAIL tx_only_acks: tx %0d rx %0d want 4 0", tx_acks, rx_acks); end
        tx_if.cyc = 1'b0; tx_if.stb = 1'b0;
        tick();
        n_assert++;
        if (gnt !== 2'b00 || m_if.cyc !== 1'b0) begin n_fail++; $display("FAIL tx_only_gap: gnt %b cyc %b want 00 0", gnt, m_if.cyc); end
        tick();
    endtask

    task automatic test_tie();
        apply_reset();
        tx_if.cyc = 1'b1; rx_if.cyc = 1'b1;
        tick();
        n_assert++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL tie_first: gnt %b want 01", gnt); end
        tx_if.cyc = 1'b0;
        tick();
        n_assert++;
        if (gnt !== 2'b00 || m_if.cyc !== 1'b0) begin n_fail++; $display("FAIL tie_gap: gnt %b cyc %b want 00 0", gnt, m_if.cyc); end
        tick();
        n_assert++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL tie_idle: gnt %b want 00", gnt); end
        tick();
        n_assert++;
        if (gnt !== 2'b10) begin n_fail++; $display("FAIL tie_rx_turn: gnt %b want 10", gnt); end
        rx_if.cyc = 1'b0;
        tick();
        tick();
        tx_if.cyc = 1'b1; rx_if.cyc = 1'b1;
        tick();
        n_assert++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL tie_second: gnt %b want 01", gnt); end
        tx_if.cyc = 1'b0; rx_if.cyc = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_yield();
        tx_if.cyc = 1'b1; tx_if.stb = 1'b1; tx_if.adr = 32'h0000_1100;
        tick();
        rx_if.cyc = 1'b1;
        for (int i = 0; i < MAX_BEATS; i++) begin
            #1;
            n_assert++;
            if (tx_if.yield !== 1'b0) begin n_fail++; $display("FAIL yield_early: beat %0d yield %b want 0", i, tx_if.yield); end
            m_if.ack = 1'b1;
            tick();
        end
        m_if.ack = 1'b0;
        #1;
        n_assert++;
        if (tx_if.yield !== 1'b1 || rx_if.yield !== 1'b0) begin
            n_fail++; $display("FAIL yield_at_max: tx %b rx %b want 1 0", tx_if.yield, rx_if.yield);
        end
        m_if.ack = 1'b1;
        tick();
        m_if.ack = 1'b0;
        #1;
        n_assert++;
        if (tx_if.yield !== 1'b1) begin n_fail++; $display("FAIL yield_saturate: got %b want 1", tx_if.yield); end
        rx_if.cyc = 1'b0;
        #1;
        n_assert++;
        if (tx_if.yield !== 1'b0) begin n_fail++; $display("FAIL yield_no_waiter: got %b want 0", tx_if.yield); end
        rx_if.cyc = 1'b1;
        tx_if.cyc = 1'b0; tx_if.stb = 1'b0;
        tick();
        tick();
        tick();
        n_assert++;
        if (gnt !== 2'b10 || rx_if.yield !== 1'b0) begin
            n_fail++; $display("FAIL yield_handover: gnt %b rx_yield %b want 10 0", gnt, rx_if.yield);
        end
        rx_if.cyc = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_rx_write();
        rx_if.cyc = 1'b1; rx_if.stb = 1'b1; rx_if.we = 1'b1;
        rx_if.dat = 32'hDEAD_BEEF; rx_if.adr = 32'h0000_2000;
        m_if.ack = 1'b1;
        #1;
        n_assert++;
        if (rx_if.ack !== 1'b0 || tx_if.ack !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_ignored: rx %b tx %b want 0 0", rx_if.ack, tx_if.ack);
        end
        m_if.ack = 1'b0;
        tick();
        n_assert++;
        if (gnt !== 2'b10 || m_if.we !== 1'b1) begin n_fail++; $display("FAIL rx_grant: gnt %b we %b want 10 1", gnt, m_if.we); end
        n_assert++;
        if (m_if.dat !== 32'hDEAD_BEEF || m_if.adr !== 32'h0000_2000) begin
            n_fail++; $display("FAIL rx_bus: dat %h adr %h want deadbeef 00002000", m_if.dat, m_if.adr);
        end
        tx_if.cyc = 1'b1; tx_if.stb = 1'b1; tx_if.adr = 32'h0000_3000;
        m_if.ack = 1'b1;
        #1;
        n_assert++;
        if (rx_if.ack !== 1'b1 || tx_if.ack !== 1'b0) begin
            n_fail++; $display("FAIL rx_ack_route: rx %b tx %b want 1 0", rx_if.ack, tx_if.ack);
        end
        tick();
        rx_if.stb = 1'b0;
        #1;
        n_assert++;
        if (rx_if.ack !== 1'b0) begin n_fail++; $display("FAIL ack_without_stb: rx_ack %b want 0", rx_if.ack); end
        m_if.ack = 1'b0;
        rx_if.cyc = 1'b0; rx_if.we = 1'b0;
        tick();
        n_assert++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL rx_release: gnt %b want 00", gnt); end
        tick();
        tick();
        n_assert++;
        if (gnt !== 2'b01 || m_if.adr !== 32'h0000_3000 || m_if.we !== 1'b0) begin
            n_fail++; $display("FAIL tx_after_rx: gnt %b adr %h we %b want 01 00003000 0", gnt, m_if.adr, m_if.we);
        end
        tx_if.cyc = 1'b0; tx_if.stb = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        rx_if.cyc = 1'b1; rx_if.stb = 1'b1; rx_if.we = 1'b1; rx_if.adr = 32'h0000_2000;
        tick();
        m_if.ack = 1'b1;
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        n_assert++;
        if (m_if.cyc !== 1'b0 || m_if.stb !== 1'b0 || gnt !== 2'b00 || rx_if.ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_burst: cyc %b stb %b gnt %b ack %b want 0 0 00 0", m_if.cyc, m_if.stb, gnt, rx_if.ack);
        end
        m_if.ack = 1'b0;
        tick();
        rst = 1'b0;
        tx_if.cyc = 1'b1;
        tick();
        n_assert++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL reset_tie: gnt %b want 01", gnt); end
        tx_if.cyc = 1'b0; rx_if.cyc = 1'b0; rx_if.stb = 1'b0; rx_if.we = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        tx_if.cyc = 1'b1; tx_if.stb = 1'b1; tx_if.adr = 32'h0000_4000;
        tick();
        for (int k = 1; k < TIMEOUT; k++) begin
            #1;
            n_assert++;
            if (tx_if.err !== 1'b0 || m_if.cyc !== 1'b1) begin
                n_fail++; $display("FAIL stall_%0d: err %b cyc %b want 0 1", k, tx_if.err, m_if.cyc);
            end
            tick();
        end
        #1;
`ifdef SD_ARB_TIMEOUT_EN
        n_assert++;
        if (tx_if.err !== 1'b1 || rx_if.err !== 1'b0 || m_if.cyc !== 1'b0 || m_if.stb !== 1'b0) begin
            n_fail++; $display("FAIL timeout_abort: tx_err %b rx_err %b cyc %b stb %b want 1 0 0 0", tx_if.err, rx_if.err, m_if.cyc, m_if.stb);
        end
        tick();
        n_assert++;
        if (tx_if.err !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL timeout_gap: err %b gnt %b want 0 00", tx_if.err, gnt); end
        tick();
        tick();
        n_assert++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL timeout_refuse: gnt %b want 00", gnt); end
        tx_if.cyc = 1'b0; tx_if.stb = 1'b0;
        tick();
        tx_if.cyc = 1'b1; tx_if.stb = 1'b1;
        tick();
        n_assert++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL timeout_regrant: gnt %b want 01", gnt); end
`else
        n_assert++;
        if (tx_if.err !== 1'b0 || m_if.cyc !== 1'b1) begin
            n_fail++; $display("FAIL no_timeout: err %b cyc %b want 0 1", tx_if.err, m_if.cyc);
        end
        repeat (12) tick();
        n_assert++;
        if (gnt !== 2'b01 || m_if.cyc !== 1'b1 || tx_if.err !== 1'b0 || rx_if.err !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout_hold: gnt %b cyc %b err %b%b want 01 1 00", gnt, m_if.cyc, tx_if.err, rx_if.err);
        end
`endif
        m_if.ack = 1'b1;
        tick();
        m_if.ack = 1'b0;
        tx_if.cyc = 1'b0; tx_if.stb = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_tx_only();
        test_tie();
        test_yield();
        test_rx_write();
        test_reset_mid_burst();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
